// File: rtl/grid_pkg.sv
// Shared constants and types for the grid stream loader.
// ASCII codes for the puzzle text, the loader state encoding and the
// character classes produced by grid_char_decode.
package grid_pkg;

  localparam logic [7:0] CH_ROLL  = 8'h40;  // '@'
  localparam logic [7:0] CH_EMPTY = 8'h2E;  // '.'
  localparam logic [7:0] CH_LF    = 8'h0A;  // '\n'
  localparam logic [7:0] CH_CR    = 8'h0D;  // '\r'

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    ERR
  } load_state_t;

  typedef enum logic [2:0] {
    CLS_ROLL,
    CLS_EMPTY,
    CLS_EOL,
    CLS_SKIP,
    CLS_BAD
  } char_cls_t;

endpackage

// File: rtl/grid_char_decode.sv
// Combinational byte classifier for the grid loader.
// A carriage return is classed as CLS_SKIP only when GRID_LOADER_CRLF_EN
// is defined; otherwise it is treated like any other illegal byte.
module grid_char_decode
  import grid_pkg::*;
(
  input  logic [7:0] char_in,
  output char_cls_t  cls
);

  // Map each byte onto the class the loader FSM acts on.
  always_comb begin
    cls = CLS_BAD;
    case (char_in)
      CH_ROLL:  cls = CLS_ROLL;
      CH_EMPTY: cls = CLS_EMPTY;
      CH_LF:    cls = CLS_EOL;
`ifdef GRID_LOADER_CRLF_EN
      CH_CR:    cls = CLS_SKIP;
`endif
      default:  cls = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/grid_stream_loader.sv
// Byte-stream to bit-grid loader. Decodes '@', '.' and '\n' into a
// WIDTH x DEPTH grid, hands it over with a valid/ack handshake and flags
// malformed text with a sticky error. Optional macro: GRID_LOADER_CRLF_EN
// (accept and ignore '\r' so CRLF text loads like LF text).
module grid_stream_loader
  import grid_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 16,
  localparam int GRID_W = WIDTH * DEPTH,
  localparam int CNT_W  = $clog2(WIDTH * DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [GRID_W-1:0] grid_out,
  output logic              grid_valid,
  input  logic              grid_ack,
  output logic [CNT_W-1:0]  roll_count,
  output logic              error
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  load_state_t        state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [GRID_W-1:0]  grid_q, grid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, grid_valid_q, error_q;
  logic               set_bit;
  logic               accept;
  logic               row_full;
  char_cls_t          cls;

  grid_char_decode u_decode (
    .char_in (in_data),
    .cls     (cls)
  );

  assign accept   = in_valid && in_ready_q;
  assign row_full = (col_q == COL_W'(WIDTH));

  // Next-state logic: character handling in LOAD, handshake in HOLD;
  // ERR holds everything frozen and simply drains input.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    count_d = count_q;
    set_bit = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          case (cls)
            CLS_ROLL, CLS_EMPTY: begin
              if (row_full) begin
                state_d = ERR;
              end else begin
                col_d   = col_q + COL_W'(1);
                set_bit = (cls == CLS_ROLL);
                if (cls == CLS_ROLL) count_d = count_q + CNT_W'(1);
              end
            end
            CLS_EOL: begin
              if (row_full) begin
                col_d = '0;
                if (row_q == ROW_W'(DEPTH - 1)) state_d = HOLD;
                else                            row_d   = row_q + ROW_W'(1);
              end else if (col_q != '0) begin
                state_d = ERR;
              end
            end
            CLS_SKIP: ;
            default: state_d = ERR;
          endcase
        end
      end
      HOLD: begin
        if (grid_ack) begin
          state_d = LOAD;
          row_d   = '0;
          col_d   = '0;
          count_d = '0;
        end
      end
      ERR:     ;
      default: state_d = ERR;
    endcase
  end

  // Grid image update: set the addressed cell on a roll, clear on hand-off.
  always_comb begin
    grid_d = grid_q;
    if (state_q == HOLD && grid_ack) begin
      grid_d = '0;
    end else if (set_bit) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (row_q == ROW_W'(r) && col_q == COL_W'(c)) grid_d[r*WIDTH + c] = 1'b1;
        end
      end
    end
  end

  // State, counters, grid and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      row_q        <= '0;
      col_q        <= '0;
      grid_q       <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      grid_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      grid_q       <= grid_d;
      count_q      <= count_d;
      in_ready_q   <= (state_d != HOLD);
      grid_valid_q <= (state_d == HOLD);
      error_q      <= (state_d == ERR);
    end
  end

  assign in_ready   = in_ready_q;
  assign grid_valid = grid_valid_q;
  assign error      = error_q;
  assign grid_out   = grid_q;
  assign roll_count = count_q;

endmodule

// File: tb/tb_grid_stream_loader.sv
// Table-driven bench for grid_stream_loader at WIDTH=4, DEPTH=3.
// Each vector is one clock: inputs driven on the falling edge, outputs
// compared 1 time unit after the following rising edge.
module tb_grid_stream_loader;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 3;
  localparam int GRID_W = WIDTH * DEPTH;
  localparam int CNT_W  = $clog2(WIDTH * DEPTH + 1);

  typedef struct {
    bit              rst;
    bit              vld;
    logic [7:0]      data;
    bit              ack;
    bit              e_rdy;
    bit              e_gv;
    bit              e_err;
    bit              chk_data;
    logic [GRID_W-1:0] e_grid;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic [GRID_W-1:0] grid_out;
  logic              grid_valid;
  logic              grid_ack;
  logic [CNT_W-1:0]  roll_count;
  logic              error;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  grid_stream_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .grid_out   (grid_out),
    .grid_valid (grid_valid),
    .grid_ack   (grid_ack),
    .roll_count (roll_count),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic v(input bit rst, input bit vld, input logic [7:0] d, input bit ack,
                   input bit rdy, input bit gv, input bit err, input bit chk,
                   input logic [GRID_W-1:0] g, input logic [CNT_W-1:0] c);
    vec_t t;
    t.rst = rst; t.vld = vld; t.data = d; t.ack = ack;
    t.e_rdy = rdy; t.e_gv = gv; t.e_err = err; t.chk_data = chk;
    t.e_grid = g; t.e_cnt = c;
    tbl.push_back(t);
  endtask

  // Plain load character: loader stays in LOAD, contents not checked.
  task automatic lds(input string s);
    for (int i = 0; i < s.len(); i++) v(0, 1, s[i], 0, 1, 0, 0, 0, '0, '0);
  endtask

  // Character sent while in ERR: drained, everything frozen.
  task automatic errs(input string s, input logic [GRID_W-1:0] g, input logic [CNT_W-1:0] c);
    for (int i = 0; i < s.len(); i++) v(0, 1, s[i], 1, 1, 0, 1, 1, g, c);
  endtask

  task automatic chk1(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    @(negedge clk);
    reset    = t.rst;
    in_valid = t.vld;
    in_data  = t.data;
    grid_ack = t.ack;
    @(posedge clk);
    #1;
    chk1("in_ready",   idx, 32'(in_ready),   32'(t.e_rdy));
    chk1("grid_valid", idx, 32'(grid_valid), 32'(t.e_gv));
    chk1("error",      idx, 32'(error),      32'(t.e_err));
    if (t.chk_data) begin
      chk1("grid_out",   idx, 32'(grid_out),   32'(t.e_grid));
      chk1("roll_count", idx, 32'(roll_count), 32'(t.e_cnt));
    end
    $display("vec %0d rst=%0b vld=%0b data=%02h ack=%0b -> rdy=%0b gv=%0b err=%0b grid=%03h cnt=%0d",
             idx, t.rst, t.vld, t.data, t.ack, in_ready, grid_valid, error, grid_out, roll_count);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; grid_ack = 1'b0;

    // Reset state
    v(1, 0, 8'h00, 0, 1, 0, 0, 1, 12'h000, 0);
    // First grid, final '\n' raises grid_valid after one edge
    lds("@@.@\n.@@.\n@..@");
    v(0, 1, 8'h0A, 0, 0, 1, 0, 1, 12'h96B, 7);
    // Hold: idle, then a byte offered while in_ready=0 must be ignored
    v(0, 0, 8'h00, 0, 0, 1, 0, 1, 12'h96B, 7);
    v(0, 1, 8'h40, 0, 0, 1, 0, 1, 12'h96B, 7);
    // Ack clears and returns to LOAD
    v(0, 0, 8'h00, 1, 1, 0, 0, 1, 12'h000, 0);
    // Empty grid
    lds("....\n....\n....");
    v(0, 1, 8'h0A, 0, 0, 1, 0, 1, 12'h000, 0);
    v(0, 0, 8'h00, 1, 1, 0, 0, 1, 12'h000, 0);
    // Ack outside HOLD ignored; then short row "@@.\n" -> ERR
    v(0, 1, 8'h40, 1, 1, 0, 0, 1, 12'h001, 1);
    lds("@.");
    v(0, 1, 8'h0A, 0, 1, 0, 1, 1, 12'h003, 2);
    errs("@\n@@@@\n.", 12'h003, 2);
    // Reset mid-load discards partial grid, then long row
    v(1, 0, 8'h00, 0, 1, 0, 0, 1, 12'h000, 0);
    lds("@@");
    v(1, 0, 8'h00, 0, 1, 0, 0, 1, 12'h000, 0);
    lds("@@@@");
    v(0, 1, 8'h40, 0, 1, 0, 1, 1, 12'h00F, 4);
    errs("\n", 12'h00F, 4);
    // Reset, blank lines ignored, clean load
    v(1, 0, 8'h00, 0, 1, 0, 0, 1, 12'h000, 0);
    lds("\n\n@...\n\n.@..\n..@.");
    v(0, 1, 8'h0A, 0, 0, 1, 0, 1, 12'h421, 3);
    v(0, 0, 8'h00, 1, 1, 0, 0, 1, 12'h000, 0);
    // Illegal byte
    lds(".@");
    v(0, 1, 8'h78, 0, 1, 0, 1, 1, 12'h002, 1);
    v(1, 0, 8'h00, 0, 1, 0, 0, 1, 12'h000, 0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // CRLF corner case, written out by hand
    begin
      int base;
      vec_t s[$];
      tbl.delete();
`ifdef GRID_LOADER_CRLF_EN
      lds("@@@@\r\n@@@@\r\n@@@@\r");
      v(0, 1, 8'h0A, 0, 0, 1, 0, 1, 12'hFFF, 12);
      v(0, 0, 8'h00, 1, 1, 0, 0, 1, 12'h000, 0);
`else
      lds("@@@@");
      v(0, 1, 8'h0D, 0, 1, 0, 1, 1, 12'h00F, 4);
      errs("\n@@@@\r\n", 12'h00F, 4);
`endif
      base = 1000;
      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], base + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
